// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: bundles the decode-side trap requests, CP0 inputs and the
// exception/redirect outputs of exc_ctrl.
//   slave  : exc_ctrl side (requests/status/epc in, pulses/redirect out)
//   master : pipeline/CP0 side (the opposite directions)
interface exc_ctrl_if;
  logic        syscall_req;
  logic        break_req;
  logic        teq_req;
  logic        eret_req;
  logic        irq;
  logic [31:0] instr_pc;
  logic [31:0] status;
  logic [31:0] epc;
  logic        exception;
  logic        eret;
  logic [31:0] cause;
  logic [31:0] exc_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_ack;
  modport slave (
    input  syscall_req, break_req, teq_req, eret_req, irq, instr_pc, status, epc,
    output exception, eret, cause, exc_pc, stall, redirect, redirect_pc, irq_ack
  );
  modport master (
    output syscall_req, break_req, teq_req, eret_req, irq, instr_pc, status, epc,
    input  exception, eret, cause, exc_pc, stall, redirect, redirect_pc, irq_ack
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception initiator for CP0. Picks one trap (eret > syscall >
// break > teq > interrupt) against CP0 status, pulses exception/eret with
// cause and pc, stalls the pipeline, then redirects fetch.
//   clk, rst (async, active-low)
//   bus.slave : trap requests, irq, instr_pc, status, epc in;
//               exception, eret, cause, exc_pc, stall, redirect,
//               redirect_pc, irq_ack out (all registered)
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input logic        clk,
  input logic        rst,
  exc_ctrl_if.slave  bus
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   irq_prev_q, irq_prev_d;
  logic                   int_pend_q, int_pend_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   is_eret_q, is_eret_d;
  logic [4:0]             code_q, code_d;
  logic [31:0]            pc_q, pc_d;
  logic                   exception_q, exception_d;
  logic                   eret_q, eret_d;
  logic                   stall_q, stall_d;
  logic                   redirect_q, redirect_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic                   irq_ack_q, irq_ack_d;
  logic                   take_sys, take_brk, take_teq, take_int, win, only_int;
  logic                   unused_status;
  assign unused_status = ^bus.status[31:5];
  assign take_sys = bus.status[0] & bus.status[1] & bus.syscall_req;
  assign take_brk = bus.status[0] & bus.status[2] & bus.break_req;
  assign take_teq = bus.status[0] & bus.status[3] & bus.teq_req;
  assign take_int = bus.status[0] & bus.status[4] & int_pend_q;
  assign win      = bus.eret_req | take_sys | take_brk | take_teq | take_int;
  assign only_int = ~(bus.eret_req | take_sys | take_brk | take_teq);
  assign bus.exception   = exception_q;
  assign bus.eret        = eret_q;
  assign bus.cause       = {25'd0, code_q, 2'b00};
  assign bus.exc_pc      = pc_q;
  assign bus.stall       = stall_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.irq_ack     = irq_ack_q;
  // Outputs are computed for the next state so they appear registered
  // during the state they belong to.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_eret_d     = is_eret_q;
    code_d        = code_q;
    pc_d          = pc_q;
    exception_d   = 1'b0;
    eret_d        = 1'b0;
    irq_ack_d     = 1'b0;
    redirect_d    = 1'b0;
    stall_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    sync_d        = {sync_q[SYNC_STAGES-2:0], bus.irq};
    irq_prev_d    = sync_q[SYNC_STAGES-1];
    // Pending clears at the end of the acknowledging COMMIT cycle.
    int_pend_d    = (int_pend_q & ~irq_ack_q) | (sync_q[SYNC_STAGES-1] & ~irq_prev_q);
    case (state_q)
      IDLE: if (win) begin
        state_d     = COMMIT;
        is_eret_d   = bus.eret_req;
        code_d      = bus.eret_req ? 5'h00 : take_sys ? 5'h08 : take_brk ? 5'h09 :
                      take_teq ? 5'h0D : 5'h00;
        pc_d        = bus.instr_pc;
        stall_d     = 1'b1;
        exception_d = ~bus.eret_req;
        eret_d      = bus.eret_req;
        irq_ack_d   = only_int;
      end
      COMMIT: begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
        stall_d = 1'b1;
      end
      FLUSH: begin
        stall_d = 1'b1;
        if (cnt_q == '0) begin
          state_d       = REDIRECT;
          redirect_d    = 1'b1;
          redirect_pc_d = is_eret_q ? bus.epc : HANDLER_ADDR;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      irq_prev_q    <= 1'b0;
      int_pend_q    <= 1'b0;
      cnt_q         <= '0;
      is_eret_q     <= 1'b0;
      code_q        <= '0;
      pc_q          <= '0;
      exception_q   <= 1'b0;
      eret_q        <= 1'b0;
      stall_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      irq_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      irq_prev_q    <= irq_prev_d;
      int_pend_q    <= int_pend_d;
      cnt_q         <= cnt_d;
      is_eret_q     <= is_eret_d;
      code_q        <= code_d;
      pc_q          <= pc_d;
      exception_q   <= exception_d;
      eret_q        <= eret_d;
      stall_q       <= stall_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      irq_ack_q     <= irq_ack_d;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: table-driven trap vectors plus hand sequences for irq and reset.
module tb_exc_ctrl;
  logic clk, rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exc_ctrl_if bus();
  exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  req;
    logic [31:0] status;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        taken;
    logic        is_eret;
    logic [31:0] cause;
    logic [31:0] rpc;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_req();
    {bus.eret_req, bus.syscall_req, bus.break_req, bus.teq_req} = 4'b0;
  endtask
  task automatic run_vec(input vec_t v);
    {bus.eret_req, bus.syscall_req, bus.break_req, bus.teq_req} = v.req;
    bus.status   = v.status;
    bus.instr_pc = v.pc;
    bus.epc      = v.epc;
    tick();
    clear_req();
    if (v.taken) begin
      chk("commit_exception", 32'(bus.exception), 32'(!v.is_eret));
      chk("commit_eret", 32'(bus.eret), 32'(v.is_eret));
      chk("commit_stall", 32'(bus.stall), 32'd1);
      chk("commit_irq_ack", 32'(bus.irq_ack), 32'd0);
      chk("commit_exc_pc", bus.exc_pc, v.pc);
      if (!v.is_eret) chk("commit_cause", bus.cause, v.cause);
      repeat (2) begin
        tick();
        chk("flush_stall", 32'(bus.stall), 32'd1);
        chk("flush_redirect", 32'(bus.redirect), 32'd0);
      end
      tick();
      chk("redirect", 32'(bus.redirect), 32'd1);
      chk("redirect_pc", bus.redirect_pc, v.rpc);
      chk("redirect_no_exc", 32'(bus.exception), 32'd0);
      tick();
      chk("idle_stall", 32'(bus.stall), 32'd0);
    end else begin
      chk("masked_stall", 32'(bus.stall), 32'd0);
      chk("masked_exception", 32'(bus.exception), 32'd0);
      chk("masked_eret", 32'(bus.eret), 32'd0);
    end
  endtask
  initial begin
    int   seen;
    vec_t v;
    // req = {eret, syscall, break, teq}
    vecs[0]  = '{4'b0100, 32'h03, 32'h0040_0100, 32'h0,          1'b1, 1'b0, 32'h20, 32'h0040_0004};
    vecs[1]  = '{4'b0100, 32'h01, 32'h0040_0104, 32'h0,          1'b0, 1'b0, 32'h00, 32'h0};
    vecs[2]  = '{4'b1000, 32'h01, 32'h0040_0300, 32'h0040_0204, 1'b1, 1'b1, 32'h00, 32'h0040_0204};
    vecs[3]  = '{4'b0011, 32'h1F, 32'h0040_0400, 32'h0,          1'b1, 1'b0, 32'h24, 32'h0040_0004};
    vecs[4]  = '{4'b0001, 32'h09, 32'h0040_0408, 32'h0,          1'b1, 1'b0, 32'h34, 32'h0040_0004};
    vecs[5]  = '{4'b0010, 32'h05, 32'h0040_040C, 32'h0,          1'b1, 1'b0, 32'h24, 32'h0040_0004};
    vecs[6]  = '{4'b0110, 32'h03, 32'h0040_0410, 32'h0,          1'b1, 1'b0, 32'h20, 32'h0040_0004};
    vecs[7]  = '{4'b1100, 32'h00, 32'h0040_0414, 32'h0040_0500, 1'b1, 1'b1, 32'h00, 32'h0040_0500};
    vecs[8]  = '{4'b1111, 32'h1F, 32'h0040_0418, 32'h0040_0600, 1'b1, 1'b1, 32'h00, 32'h0040_0600};
    vecs[9]  = '{4'b0100, 32'h0E, 32'h0040_041C, 32'h0,          1'b0, 1'b0, 32'h00, 32'h0};
    vecs[10] = '{4'b0001, 32'h07, 32'h0040_0420, 32'h0,          1'b0, 1'b0, 32'h00, 32'h0};
    rst = 1'b0;
    clear_req();
    bus.irq = 1'b0;
    bus.instr_pc = '0;
    bus.status = '0;
    bus.epc = '0;
    repeat (2) tick();
    chk("rst_exception", 32'(bus.exception), 32'd0);
    chk("rst_eret", 32'(bus.eret), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_redirect", 32'(bus.redirect), 32'd0);
    chk("rst_irq_ack", 32'(bus.irq_ack), 32'd0);
    chk("rst_cause", bus.cause, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    // break+teq+irq together: break wins, irq taken once back in IDLE
    v = '{4'b0011, 32'h1F, 32'h0040_0700, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0040_0004};
    bus.irq = 1'b1;
    run_vec(v);
    tick();
    chk("int_exception", 32'(bus.exception), 32'd1);
    chk("int_cause", bus.cause, 32'd0);
    chk("int_irq_ack", 32'(bus.irq_ack), 32'd1);
    repeat (3) tick();
    chk("int_redirect", 32'(bus.redirect), 32'd1);
    chk("int_redirect_pc", bus.redirect_pc, 32'h0040_0004);
    seen = 0;
    repeat (4) begin
      tick();
      seen += int'(bus.exception);
    end
    chk("int_no_retake", 32'(seen), 32'd0);
    bus.irq = 1'b0;
    repeat (4) tick();
    // masked interrupt stays pending until enabled
    bus.status = 32'h01;
    bus.irq = 1'b1;
    repeat (3) tick();
    bus.irq = 1'b0;
    repeat (4) tick();
    chk("irq_masked_stall", 32'(bus.stall), 32'd0);
    chk("irq_masked_exc", 32'(bus.exception), 32'd0);
    bus.status = 32'h11;
    tick();
    chk("irq_pend_exception", 32'(bus.exception), 32'd1);
    chk("irq_pend_ack", 32'(bus.irq_ack), 32'd1);
    chk("irq_pend_cause", bus.cause, 32'd0);
    repeat (3) tick();
    chk("irq_pend_redirect", 32'(bus.redirect), 32'd1);
    tick();
    tick();
    chk("irq_pend_cleared", 32'(bus.exception), 32'd0);
    // reset asserted during FLUSH
    bus.status = 32'h03;
    bus.syscall_req = 1'b1;
    bus.instr_pc = 32'h0040_0800;
    tick();
    clear_req();
    chk("rstseq_commit", 32'(bus.exception), 32'd1);
    tick();
    chk("rstseq_flush_stall", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstseq_stall", 32'(bus.stall), 32'd0);
    chk("rstseq_redirect", 32'(bus.redirect), 32'd0);
    chk("rstseq_cause", bus.cause, 32'd0);
    chk("rstseq_exc_pc", bus.exc_pc, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      seen += int'(bus.redirect) + int'(bus.stall);
    end
    chk("rstseq_no_redirect", 32'(seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
